peripheral_uart_tx_arbiter_wb: RTL and testbench
================================================

# peripheral_uart_tx_arbiter_wb

Message-granular round-robin arbiter that shares one UART transmitter (and its 16-entry TX FIFO) among several on-chip byte producers in the MPSoC. Each requester presents a valid/ready byte stream with a `last` marker. The arbiter grants one requester at a time, holds the grant until that requester's message ends, and throttles pushes so the FIFO never overruns. It sits between the requesters and the transmitter's `tf_push`/`wb_dat_i`/`tf_count` ports, and releases a stalled requester after a watchdog timeout.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `FIFO_DEPTH`, 16: TX FIFO depth in bytes.
- `COUNTER_W`, 5: width of `tf_count`.
- `TIMEOUT`, 1024: idle cycles tolerated mid-message before the grant is revoked (≥2).

Ports:
- `clk` in 1: clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `req_valid` in NREQ: byte valid per requester.
- `req_data` in NREQ*8: byte per requester; requester i uses bits [8i+7:8i].
- `req_last` in NREQ: byte is the final byte of its message.
- `req_ready` out NREQ: byte accepted this cycle when ANDed with valid (combinational).
- `tf_count` in COUNTER_W: current TX FIFO occupancy.
- `tx_reset` in 1: FIFO flush request (the FCR TX-reset bit).
- `tf_push` out 1: registered one-cycle push strobe to the FIFO.
- `tf_data` out 8: registered byte, drives the transmitter `wb_dat_i`.
- `grant` out NREQ: one-hot owner, or zero.
- `busy` out 1: `grant` is non-zero.
- `timeout_evt` out 1: one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- Reset values:
  - All outputs 0.
  - Round-robin pointer `rr_ptr` = 0.
  - Watchdog = 0.
  - State S_IDLE.
- S_IDLE:
  - If any `req_valid` is high, pick the first valid index searching from `rr_ptr` upward, with wrap-around.
  - Register the one-hot `grant` for that index and go to S_XFER.
  - No byte is accepted in S_IDLE.
- S_XFER:
  - `req_ready[g]` = `space_ok` AND NOT `tx_reset`.
  - All other `req_ready` bits are 0.
  - `space_ok` = (`tf_count` + `tf_push`) < FIFO_DEPTH. Compute this at COUNTER_W+1 bits. The `tf_push` term covers the one push in flight that `tf_count` does not yet reflect.
  - Pops by the transmitter are ignored; throttling is conservative.
- Accepted beat (valid & ready):
  - Next cycle, `tf_push` = 1 and `tf_data` = the accepted byte.
  - Watchdog clears.
  - If `req_last` is also high: `grant` → 0, `rr_ptr` ← g+1 mod NREQ, go to S_IDLE.
- Watchdog:
  - Increments each S_XFER cycle in which `req_valid[g]` is 0.
  - Holds its value (does not increment) while `space_ok` = 0, so FIFO backpressure never triggers a timeout.
  - When the count reaches TIMEOUT−1 and valid is still low: pulse `timeout_evt`, `grant` → 0, `rr_ptr` ← g+1, go to S_IDLE, clear the watchdog.
- `tx_reset` (any state):
  - `tf_push` is forced to 0 next cycle, so a byte accepted the cycle before is discarded.
  - `grant` → 0 and state goes to S_IDLE.
  - `rr_ptr` ← g+1 if a grant was held.
  - Watchdog clears.
  - No new grant is issued while `tx_reset` is high.
- Same-cycle precedence: `tx_reset` > last beat > timeout. A last beat accepted on the timeout cycle completes normally, with no `timeout_evt`.
- Requesters must hold `data`/`last` stable while valid is high and ready is low.

## Timing
- Grant latency: valid seen in S_IDLE at cycle t → `grant` at t+1 → first accept at t+1 at the earliest → `tf_push` at t+2.
- Sustained throughput: 1 byte/cycle while `space_ok` holds.
- Message turnaround: last beat at t → S_IDLE at t+1 → next grant at t+2. There is one dead cycle per message.
- `tf_push` is never high on two consecutive cycles that would push the FIFO above FIFO_DEPTH.

## Structure
- In `peripheral_wb_pkg`:
  - State enum `uart_txarb_state_t` {S_IDLE, S_XFER}.
  - `UART_TXARB_TIMEOUT_W` = clog2(TIMEOUT).
- Sub-module `peripheral_uart_rr_picker_wb`: combinational; inputs `req` [NREQ] and `ptr`; outputs one-hot `gnt` and binary `idx`.

## Test plan
- Single message: requester 1 sends 0x41, 0x42, 0x43 (last) → `grant`=0010 one cycle after valid; pushes 0x41/0x42/0x43 on three consecutive cycles; back to S_IDLE; `rr_ptr`=2.
- Fairness: requesters 0, 2 and 3 each hold a 2-byte message pending → grant order 2,3,0 from `rr_ptr`=2, then 2 again; no interleaving of bytes within a message.
- Backpressure: `tf_count` held at 15 → first byte pushes, then `req_ready`=0 while `tf_count`+`tf_push`=16; release at `tf_count`=14 → next push; `timeout_evt` never fires.
- Watchdog, TIMEOUT=8: granted requester drops valid after byte 1 → `timeout_evt` pulses on the 8th idle cycle; `grant`=0; next requester is granted.
- `tx_reset` mid-message, pulsed the cycle after an accept → no `tf_push` the next cycle; `grant`=0; S_IDLE; re-grant only after `tx_reset` falls.
- Async reset during S_XFER with `tf_push`=1 → all outputs 0 immediately; `rr_ptr`=0 after release.

Source files
------------

// File: rtl/peripheral_wb_pkg.sv
// -----------------------------------------------------------------------------
// peripheral_wb_pkg
// Shared types and constants for the UART TX arbiter slice.
//   uart_txarb_state_t    : arbiter FSM state (idle / transferring a message)
//   UART_TXARB_TIMEOUT_W  : watchdog width for the default timeout
//   uart_txarb_timeout_w  : watchdog width for any timeout value
// -----------------------------------------------------------------------------
package peripheral_wb_pkg;

  localparam int UART_TXARB_TIMEOUT_DEFAULT = 1024;
  localparam int UART_TXARB_TIMEOUT_W       = $clog2(UART_TXARB_TIMEOUT_DEFAULT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } uart_txarb_state_t;

  // Watchdog width: enough bits to hold TIMEOUT-1 (at least one bit).
  function automatic int uart_txarb_timeout_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/peripheral_uart_rr_picker_wb.sv
// -----------------------------------------------------------------------------
// peripheral_uart_rr_picker_wb
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping around to 0.
//   req [NREQ]  : request vector
//   ptr [PTR_W] : index with highest priority
//   gnt [NREQ]  : one-hot winner (zero when req is zero)
//   idx [PTR_W] : binary index of the winner (zero when req is zero)
// -----------------------------------------------------------------------------
module peripheral_uart_rr_picker_wb #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] cand_s;
  logic             found_s;

  // Scan NREQ candidates starting at ptr; the first requester found wins.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_s = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum_s >= (PTR_W+1)'(NREQ)) begin
        sum_s = sum_s - (PTR_W+1)'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[PTR_W-1:0];
      if (!found_s && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/peripheral_uart_tx_arbiter_wb.sv
// -----------------------------------------------------------------------------
// peripheral_uart_tx_arbiter_wb
// Message-granular round-robin arbiter sharing one UART TX FIFO among NREQ
// byte producers. A grant is held until the owner's last byte, until the
// watchdog expires, or until the FIFO is flushed.
//   clk, wb_rst_i        : clock, asynchronous active-high reset
//   req_valid/data/last  : per-requester byte streams (byte i at [8i+7:8i])
//   req_ready            : combinational accept, only for the owner
//   tf_count, tx_reset   : FIFO occupancy and FIFO flush request
//   tf_push, tf_data     : registered push strobe and byte towards the FIFO
//   grant, busy          : one-hot owner and "owner present"
//   timeout_evt          : one-cycle pulse when the watchdog revokes a grant
// -----------------------------------------------------------------------------
module peripheral_uart_tx_arbiter_wb
  import peripheral_wb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int COUNTER_W  = 5,
  parameter int TIMEOUT    = UART_TXARB_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 wb_rst_i,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*8-1:0]    req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic [COUNTER_W-1:0] tf_count,
  input  logic                 tx_reset,
  output logic                 tf_push,
  output logic [7:0]           tf_data,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 timeout_evt
);

  localparam int                  PTR_W    = $clog2(NREQ);
  localparam int                  WD_W     = uart_txarb_timeout_w(TIMEOUT);
  localparam logic [PTR_W-1:0]    LAST_IDX = PTR_W'(NREQ - 1);
  localparam logic [WD_W-1:0]     WD_LIMIT = WD_W'(TIMEOUT - 1);
  localparam logic [COUNTER_W:0]  DEPTH_C  = (COUNTER_W+1)'(FIFO_DEPTH);

  uart_txarb_state_t state_r;
  logic [NREQ-1:0]   grant_r;
  logic [PTR_W-1:0]  gidx_r;
  logic [PTR_W-1:0]  rr_ptr_r;
  logic [WD_W-1:0]   wdog_r;
  logic              tf_push_r;
  logic [7:0]        tf_data_r;
  logic              timeout_evt_r;

  logic [NREQ-1:0]   pick_gnt_s;
  logic [PTR_W-1:0]  pick_idx_s;
  logic [COUNTER_W:0] occ_s;
  logic              space_ok_s;
  logic [NREQ-1:0]   ready_s;
  logic              accept_s;
  logic              valid_g_s;
  logic              last_g_s;
  logic [7:0]        data_g_s;
  logic [PTR_W-1:0]  rr_next_s;

  peripheral_uart_rr_picker_wb #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req (req_valid),
    .ptr (rr_ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s)
  );

  // The push in flight is not yet in tf_count, so count it here; pops are ignored.
  assign occ_s      = {1'b0, tf_count} + {{COUNTER_W{1'b0}}, tf_push_r};
  assign space_ok_s = (occ_s < DEPTH_C);

  assign valid_g_s  = req_valid[gidx_r];
  assign last_g_s   = req_last[gidx_r];
  assign data_g_s   = req_data[{gidx_r, 3'b000} +: 8];
  assign rr_next_s  = (gidx_r == LAST_IDX) ? '0 : gidx_r + PTR_W'(1);

  // Only the owner may be ready, and never while the FIFO is full or flushing.
  always_comb begin
    ready_s = '0;
    if ((state_r == S_XFER) && space_ok_s && !tx_reset) begin
      ready_s = grant_r;
    end else begin
      ready_s = '0;
    end
  end

  assign accept_s    = |(req_valid & ready_s);
  assign req_ready   = ready_s;
  assign tf_push     = tf_push_r;
  assign tf_data     = tf_data_r;
  assign grant       = grant_r;
  assign busy        = |grant_r;
  assign timeout_evt = timeout_evt_r;

  // Arbiter FSM, FIFO push register and watchdog.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r       <= S_IDLE;
      grant_r       <= '0;
      gidx_r        <= '0;
      rr_ptr_r      <= '0;
      wdog_r        <= '0;
      tf_push_r     <= 1'b0;
      tf_data_r     <= 8'h00;
      timeout_evt_r <= 1'b0;
    end else begin
      // accept_s is already blocked by tx_reset, so a flush never pushes.
      tf_push_r     <= accept_s;
      timeout_evt_r <= 1'b0;
      if (accept_s) begin
        tf_data_r <= data_g_s;
      end else begin
        tf_data_r <= tf_data_r;
      end

      if (tx_reset) begin
        state_r <= S_IDLE;
        grant_r <= '0;
        wdog_r  <= '0;
        if (state_r == S_XFER) begin
          rr_ptr_r <= rr_next_s;
        end else begin
          rr_ptr_r <= rr_ptr_r;
        end
      end else begin
        case (state_r)
          S_IDLE: begin
            wdog_r <= '0;
            if (|req_valid) begin
              grant_r <= pick_gnt_s;
              gidx_r  <= pick_idx_s;
              state_r <= S_XFER;
            end else begin
              grant_r <= '0;
            end
          end
          S_XFER: begin
            if (accept_s) begin
              wdog_r <= '0;
              if (last_g_s) begin
                grant_r  <= '0;
                rr_ptr_r <= rr_next_s;
                state_r  <= S_IDLE;
              end else begin
                state_r  <= S_XFER;
              end
            end else if (!valid_g_s && space_ok_s) begin
              // A full FIFO freezes the watchdog; only a silent owner ages it.
              if (wdog_r == WD_LIMIT) begin
                timeout_evt_r <= 1'b1;
                grant_r       <= '0;
                rr_ptr_r      <= rr_next_s;
                state_r       <= S_IDLE;
                wdog_r        <= '0;
              end else begin
                wdog_r <= wdog_r + WD_W'(1);
              end
            end else begin
              wdog_r <= wdog_r;
            end
          end
          default: begin
            state_r <= S_IDLE;
            grant_r <= '0;
            wdog_r  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_peripheral_uart_tx_arbiter_wb.sv
// -----------------------------------------------------------------------------
// tb_peripheral_uart_tx_arbiter_wb
// Directed bench for the UART TX arbiter (NREQ=4, FIFO_DEPTH=16, TIMEOUT=8).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_peripheral_uart_tx_arbiter_wb;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [4:0]  tf_count;
  logic        tx_reset;
  logic        tf_push;
  logic [7:0]  tf_data;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_evt;

  int vectors     = 0;
  int miscompares = 0;

  peripheral_uart_tx_arbiter_wb #(
    .NREQ       (4),
    .FIFO_DEPTH (16),
    .COUNTER_W  (5),
    .TIMEOUT    (8)
  ) dut (
    .clk         (clk),
    .wb_rst_i    (wb_rst_i),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tf_count    (tf_count),
    .tx_reset    (tx_reset),
    .tf_push     (tf_push),
    .tf_data     (tf_data),
    .grant       (grant),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]         = v;
    req_data[i*8 +: 8]   = d;
    req_last[i]          = l;
  endtask

  task automatic clear_reqs();
    req_valid = 4'b0000;
    req_data  = 32'h0000_0000;
    req_last  = 4'b0000;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    tx_reset = 1'b0;
    tf_count = 5'd0;
    clear_reqs();
    step();
    req_valid = 4'b1111;
    step();
    settle();
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL rst_grant got=%b exp=%b", grant, 4'b0000); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=%b", busy, 1'b0); end
    vectors++; if (tf_push !== 1'b0) begin miscompares++; $display("FAIL rst_tf_push got=%b exp=%b", tf_push, 1'b0); end
    vectors++; if (tf_data !== 8'h00) begin miscompares++; $display("FAIL rst_tf_data got=%h exp=%h", tf_data, 8'h00); end
    vectors++; if (timeout_evt !== 1'b0) begin miscompares++; $display("FAIL rst_timeout_evt got=%b exp=%b", timeout_evt, 1'b0); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_req_ready got=%b exp=%b", req_ready, 4'b0000); end
    clear_reqs();
    step();
    wb_rst_i = 1'b0;
    step();
  endtask

  task automatic test_single_message();
    step(); set_req(1, 1'b1, 8'h41, 1'b0); settle();
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL single_idle_ready got=%b exp=%b", req_ready, 4'b0000); end
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL single_idle_grant got=%b exp=%b", grant, 4'b0000); end
    step(); settle();
    vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL single_grant got=%b exp=%b", grant, 4'b0010); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=%b", busy, 1'b1); end
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL single_ready got=%b exp=%b", req_ready, 4'b0010); end
    step(); set_req(1, 1'b1, 8'h42, 1'b0); settle();
    vectors++; if ({tf_push, tf_data} !== {1'b1, 8'h41}) begin miscompares++; $display("FAIL single_push0 got=%b/%h exp=1/41", tf_push, tf_data); end
    step(); set_req(1, 1'b1, 8'h43, 1'b1); settle();
    vectors++; if ({tf_push, tf_data} !== {1'b1, 8'h42}) begin miscompares++; $display("FAIL single_push1 got=%b/%h exp=1/42", tf_push, tf_data); end
    vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL single_grant_held got=%b exp=%b", grant, 4'b0010); end
    step(); set_req(1, 1'b0, 8'h00, 1'b0); settle();
    vectors++; if ({tf_push, tf_data} !== {1'b1, 8'h43}) begin miscompares++; $display("FAIL single_push2 got=%b/%h exp=1/43", tf_push, tf_data); end
    vectors++; if ({grant, busy} !== 5'b0000_0) begin miscompares++; $display("FAIL single_release got=%b/%b exp=0000/0", grant, busy); end
    step(); settle();
    vectors++; if (tf_push !== 1'b0) begin miscompares++; $display("FAIL single_push_end got=%b exp=%b", tf_push, 1'b0); end
  endtask

  // Requesters 0, 2 and 3 hold 2-byte messages (requester 2 has two in a row);
  // the round-robin pointer starts at 2 after the single-message test.
  task automatic test_fairness();
    logic [7:0] fb [4][4];
    logic [3:0] lm [4];
    int         flen [4];
    int         fpos [4];
    logic [7:0] push_q [$];
    int         gnt_q [$];
    logic [3:0] prev_grant;
    logic [7:0] exp_push [8];
    int         exp_gnt [4];
    int         gi;
    fb[0] = '{8'hA0, 8'hA1, 8'h00, 8'h00};
    fb[1] = '{8'h00, 8'h00, 8'h00, 8'h00};
    fb[2] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    fb[3] = '{8'hD0, 8'hD1, 8'h00, 8'h00};
    lm    = '{4'b0010, 4'b0000, 4'b1010, 4'b0010};
    flen  = '{2, 0, 4, 2};
    fpos  = '{0, 0, 0, 0};
    exp_push = '{8'hC0, 8'hC1, 8'hD0, 8'hD1, 8'hA0, 8'hA1, 8'hC2, 8'hC3};
    exp_gnt  = '{2, 3, 0, 2};
    prev_grant = 4'b0000;
    for (int cyc = 0; cyc < 30; cyc++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (fpos[i] < flen[i]) set_req(i, 1'b1, fb[i][fpos[i]], lm[i][fpos[i]]);
        else set_req(i, 1'b0, 8'h00, 1'b0);
      end
      settle();
      if (tf_push === 1'b1) push_q.push_back(tf_data);
      if (grant !== 4'b0000 && grant !== prev_grant) begin
        gi = -1;
        for (int i = 0; i < 4; i++) if (grant[i]) gi = i;
        gnt_q.push_back(gi);
      end
      prev_grant = grant;
      vectors++; if ((req_ready & ~grant) !== 4'b0000) begin miscompares++; $display("FAIL fair_ready_owner cyc=%0d got=%b grant=%b exp=0000", cyc, req_ready & ~grant, grant); end
      for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) fpos[i]++;
    end
    clear_reqs();
    vectors++; if (push_q.size() !== 8) begin miscompares++; $display("FAIL fair_push_count got=%0d exp=%0d", push_q.size(), 8); end
    for (int k = 0; k < 8; k++) begin
      if (k < push_q.size()) begin
        vectors++; if (push_q[k] !== exp_push[k]) begin miscompares++; $display("FAIL fair_push[%0d] got=%h exp=%h", k, push_q[k], exp_push[k]); end
      end
    end
    vectors++; if (gnt_q.size() !== 4) begin miscompares++; $display("FAIL fair_grant_count got=%0d exp=%0d", gnt_q.size(), 4); end
    for (int k = 0; k < 4; k++) begin
      if (k < gnt_q.size()) begin
        vectors++; if (gnt_q[k] !== exp_gnt[k]) begin miscompares++; $display("FAIL fair_grant[%0d] got=%0d exp=%0d", k, gnt_q[k], exp_gnt[k]); end
      end
    end
    step();
  endtask

  // Pointer is at 3 here. The owner goes silent for 12 cycles while the FIFO is full.
  task automatic test_backpressure();
    step(); tf_count = 5'd15; set_req(3, 1'b1, 8'h55, 1'b0); settle();
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL bp_idle_grant got=%b exp=%b", grant, 4'b0000); end
    step(); settle();
    vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_first_ready got=%b exp=%b", req_ready, 4'b1000); end
    step(); set_req(3, 1'b0, 8'h00, 1'b0); settle();
    vectors++; if ({tf_push, tf_data} !== {1'b1, 8'h55}) begin miscompares++; $display("FAIL bp_push0 got=%b/%h exp=1/55", tf_push, tf_data); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_inflight_ready got=%b exp=%b", req_ready, 4'b0000); end
    for (int c = 3; c <= 13; c++) begin
      step(); tf_count = 5'd16; settle();
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_full_ready c=%0d got=%b exp=%b", c, req_ready, 4'b0000); end
      vectors++; if (timeout_evt !== 1'b0) begin miscompares++; $display("FAIL bp_no_timeout c=%0d got=%b exp=%b", c, timeout_evt, 1'b0); end
    end
    step(); tf_count = 5'd14; set_req(3, 1'b1, 8'h66, 1'b1); settle();
    vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL bp_grant_kept got=%b exp=%b", grant, 4'b1000); end
    vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_release_ready got=%b exp=%b", req_ready, 4'b1000); end
    step(); tf_count = 5'd15; set_req(3, 1'b0, 8'h00, 1'b0); settle();
    vectors++; if ({tf_push, tf_data} !== {1'b1, 8'h66}) begin miscompares++; $display("FAIL bp_push1 got=%b/%h exp=1/66", tf_push, tf_data); end
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL bp_done_grant got=%b exp=%b", grant, 4'b0000); end
    step(); tf_count = 5'd0;
    step();
  endtask

  // Pointer is at 0: requester 0 sends one byte and goes silent; 1 waits.
  task automatic test_watchdog();
    step(); set_req(0, 1'b1, 8'h77, 1'b0); set_req(1, 1'b1, 8'h88, 1'b1); settle();
    step(); settle();
    vectors++; if ({grant, req_ready} !== {4'b0001, 4'b0001}) begin miscompares++; $display("FAIL wd_grant got=%b/%b exp=0001/0001", grant, req_ready); end
    step(); set_req(0, 1'b0, 8'h00, 1'b0); settle();
    vectors++; if ({tf_push, tf_data} !== {1'b1, 8'h77}) begin miscompares++; $display("FAIL wd_push got=%b/%h exp=1/77", tf_push, tf_data); end
    for (int c = 3; c <= 9; c++) begin
      step(); settle();
      vectors++; if ({timeout_evt, grant} !== {1'b0, 4'b0001}) begin miscompares++; $display("FAIL wd_wait c=%0d got=%b/%b exp=0/0001", c, timeout_evt, grant); end
    end
    step(); settle();
    vectors++; if (timeout_evt !== 1'b1) begin miscompares++; $display("FAIL wd_pulse got=%b exp=%b", timeout_evt, 1'b1); end
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL wd_revoke got=%b exp=%b", grant, 4'b0000); end
    step(); settle();
    vectors++; if (timeout_evt !== 1'b0) begin miscompares++; $display("FAIL wd_pulse_end got=%b exp=%b", timeout_evt, 1'b0); end
    vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL wd_next_grant got=%b exp=%b", grant, 4'b0010); end
    step(); set_req(1, 1'b0, 8'h00, 1'b0); settle();
    vectors++; if ({tf_push, tf_data} !== {1'b1, 8'h88}) begin miscompares++; $display("FAIL wd_next_push got=%b/%h exp=1/88", tf_push, tf_data); end
    step();
  endtask

  // Pointer is at 2: flush arrives the cycle after the first accept.
  task automatic test_tx_reset();
    step(); set_req(2, 1'b1, 8'h91, 1'b0); settle();
    step(); settle();
    vectors++; if ({grant, req_ready} !== {4'b0100, 4'b0100}) begin miscompares++; $display("FAIL txr_grant got=%b/%b exp=0100/0100", grant, req_ready); end
    step(); set_req(2, 1'b1, 8'h92, 1'b0); tx_reset = 1'b1; settle();
    vectors++; if ({tf_push, tf_data} !== {1'b1, 8'h91}) begin miscompares++; $display("FAIL txr_push0 got=%b/%h exp=1/91", tf_push, tf_data); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL txr_ready got=%b exp=%b", req_ready, 4'b0000); end
    step(); settle();
    vectors++; if (tf_push !== 1'b0) begin miscompares++; $display("FAIL txr_no_push got=%b exp=%b", tf_push, 1'b0); end
    vectors++; if ({grant, busy} !== 5'b0000_0) begin miscompares++; $display("FAIL txr_revoke got=%b/%b exp=0000/0", grant, busy); end
    step(); settle();
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL txr_hold_grant got=%b exp=%b", grant, 4'b0000); end
    step(); tx_reset = 1'b0; settle();
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL txr_fall_grant got=%b exp=%b", grant, 4'b0000); end
    step(); settle();
    vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL txr_regrant got=%b exp=%b", grant, 4'b0100); end
    step(); set_req(2, 1'b1, 8'h93, 1'b1); settle();
    vectors++; if ({tf_push, tf_data} !== {1'b1, 8'h92}) begin miscompares++; $display("FAIL txr_push1 got=%b/%h exp=1/92", tf_push, tf_data); end
    step(); set_req(2, 1'b0, 8'h00, 1'b0); settle();
    vectors++; if ({tf_push, tf_data, grant} !== {1'b1, 8'h93, 4'b0000}) begin miscompares++; $display("FAIL txr_push2 got=%b/%h/%b exp=1/93/0000", tf_push, tf_data, grant); end
    step();
  endtask

  // Pointer is at 3; after reset requesters 0 and 3 compete, so 0 wins only
  // if the pointer went back to 0.
  task automatic test_async_reset();
    step(); set_req(3, 1'b1, 8'hE1, 1'b0); settle();
    step(); settle();
    vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL ar_grant got=%b exp=%b", grant, 4'b1000); end
    step(); settle();
    vectors++; if (tf_push !== 1'b1) begin miscompares++; $display("FAIL ar_pre_push got=%b exp=%b", tf_push, 1'b1); end
    #2; wb_rst_i = 1'b1; #1;
    vectors++; if ({grant, busy, tf_push, tf_data, timeout_evt, req_ready} !== 19'd0) begin miscompares++; $display("FAIL ar_outputs got=%b/%b/%b/%h/%b/%b exp=all zero", grant, busy, tf_push, tf_data, timeout_evt, req_ready); end
    step(); step();
    step(); wb_rst_i = 1'b0; clear_reqs(); set_req(0, 1'b1, 8'hA5, 1'b1); set_req(3, 1'b1, 8'hE1, 1'b0); settle();
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL ar_idle got=%b exp=%b", grant, 4'b0000); end
    step(); settle();
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL ar_rr_ptr got=%b exp=%b", grant, 4'b0001); end
    step(); clear_reqs();
    step();
  endtask

  initial begin
    test_reset();
    test_single_message();
    test_fairness();
    test_backpressure();
    test_watchdog();
    test_tx_reset();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
